// File: rtl/lcd_row_writer.sv
// HD44780 8-bit writer: power-up wait, init command burst, then refreshes both
// 16-character rows from a snapshot whenever the input text differs from it.
module lcd_row_writer #(
  parameter int POWERUP_CYC = 150000,
  parameter int EN_CYC      = 5,
  parameter int CMD_CYC     = 500,
  parameter int CLR_CYC     = 20000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] top,
  input  logic [127:0] bottom,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_en,
  output logic [7:0]   lcd_data,
  output logic         busy,
  output logic         frame_done
);

  localparam int M1   = (POWERUP_CYC > CLR_CYC) ? POWERUP_CYC : CLR_CYC;
  localparam int M2   = (CMD_CYC > EN_CYC) ? CMD_CYC : EN_CYC;
  localparam int MAXC = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {POWERUP, INIT, IDLE, REFRESH} state_t;
  typedef enum logic [1:0] {SETUP, PULSE, WAIT} phase_t;

  state_t         state_q, state_d;
  phase_t         phase_q, phase_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [5:0]     idx_q, idx_d;
  logic [255:0]   snap_q, snap_d;
  logic           rs_q, rs_d;
  logic [7:0]     data_q, data_d;
  logic           done_q, done_d;
  logic           go_refresh;
  logic [CW-1:0]  wait_last;

  // Returns {rs, data} for byte idx of the init burst or of a refresh frame.
  function automatic logic [8:0] byte_sel(input logic init_seq, input logic [5:0] idx,
                                          input logic [255:0] snap);
    logic [8:0] r;
    r = 9'h000;
    if (init_seq) begin
      case (idx)
        6'd0:    r = {1'b0, 8'h38};
        6'd1:    r = {1'b0, 8'h0C};
        6'd2:    r = {1'b0, 8'h06};
        default: r = {1'b0, 8'h01};
      endcase
    end else if (idx == 6'd0) begin
      r = {1'b0, 8'h80};
    end else if (idx == 6'd17) begin
      r = {1'b0, 8'hC0};
    end else if (idx <= 6'd16) begin
      r = {1'b1, 8'(snap >> (9'd256 - {idx, 3'b000}))};
    end else begin
      r = {1'b1, 8'(snap >> (9'd264 - {idx, 3'b000}))};
    end
    return r;
  endfunction

  // Only the clear command gets the long settle time; data bytes never do.
  assign wait_last = (!rs_q && data_q == 8'h01) ? CW'(CLR_CYC - 1) : CW'(CMD_CYC - 1);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    rs_d       = rs_q;
    data_d     = data_q;
    done_d     = 1'b0;
    go_refresh = 1'b0;
    case (state_q)
      POWERUP: begin
        if (cnt_q == CW'(POWERUP_CYC - 1)) begin
          state_d          = INIT;
          phase_d          = SETUP;
          cnt_d            = '0;
          idx_d            = 6'd0;
          {rs_d, data_d}   = byte_sel(1'b1, 6'd0, snap_q);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      IDLE: begin
        if ({top, bottom} != snap_q) go_refresh = 1'b1;
      end
      INIT, REFRESH: begin
        case (phase_q)
          SETUP: begin
            phase_d = PULSE;
            cnt_d   = '0;
          end
          PULSE: begin
            if (cnt_q == CW'(EN_CYC - 1)) begin
              phase_d = WAIT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          default: begin
            if (cnt_q != wait_last) begin
              cnt_d = cnt_q + CW'(1);
            end else if (state_q == INIT && idx_q == 6'd3) begin
              go_refresh = 1'b1;
            end else if (state_q == REFRESH && idx_q == 6'd33) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              phase_d        = SETUP;
              cnt_d          = '0;
              idx_d          = idx_q + 6'd1;
              {rs_d, data_d} = byte_sel(state_q == INIT, idx_q + 6'd1, snap_q);
            end
          end
        endcase
      end
      default: state_d = POWERUP;
    endcase
    // The snapshot is taken on the same edge the frame starts, so byte 0 sees it too.
    if (go_refresh) begin
      state_d        = REFRESH;
      phase_d        = SETUP;
      cnt_d          = '0;
      idx_d          = 6'd0;
      snap_d         = {top, bottom};
      {rs_d, data_d} = byte_sel(1'b0, 6'd0, {top, bottom});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= POWERUP;
      phase_q <= SETUP;
      cnt_q   <= '0;
      idx_q   <= 6'd0;
      snap_q  <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign lcd_en     = (state_q == INIT || state_q == REFRESH) && (phase_q == PULSE);
  assign lcd_rs     = rs_q;
  assign lcd_data   = data_q;
  assign lcd_rw     = 1'b0;
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;

endmodule

// File: tb/tb_lcd_row_writer.sv
// Bench for lcd_row_writer: a per-cycle bus timeline model built from byte lists,
// randomized text changes, and literal checks on the first frame and reset recovery.
module tb_lcd_row_writer;

  localparam int PU  = 10;
  localparam int EN  = 2;
  localparam int CMD = 3;
  localparam int CLR = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] top, bottom;
  logic         lcd_rs, lcd_rw, lcd_en, busy, frame_done;
  logic [7:0]   lcd_data;

  lcd_row_writer #(.POWERUP_CYC(PU), .EN_CYC(EN), .CMD_CYC(CMD), .CLR_CYC(CLR)) dut (
    .clk(clk), .rst(rst), .top(top), .bottom(bottom),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       en;
    logic       rs;
    logic [7:0] d;
    logic       busy;
    logic       fd;
  } exp_t;

  exp_t         q[$];
  logic [255:0] m_snap;
  bit           m_force;
  logic         m_rs;
  logic [7:0]   m_d;
  logic [7:0]   slog[$];
  int           fd_n = 0;
  int           rel = 0;
  int           en_run = 0;
  bit           armed = 0;
  bit           started = 0;
  logic         prev_en = 1'b0;
  int           cyc = 0;

  task automatic push_byte(input logic rs, input logic [7:0] d);
    exp_t e;
    int w;
    w = (!rs && d == 8'h01) ? CLR : CMD;
    e = {1'b0, rs, d, 1'b1, 1'b0};
    q.push_back(e);
    e.en = 1'b1;
    for (int i = 0; i < EN; i++) q.push_back(e);
    e.en = 1'b0;
    for (int i = 0; i < w; i++) q.push_back(e);
    m_rs = rs;
    m_d  = d;
  endtask

  task automatic build_frame(input logic [255:0] s);
    logic [255:0] t;
    exp_t e;
    push_byte(1'b0, 8'h80);
    for (int c = 0; c < 16; c++) begin
      t = s >> (248 - 8 * c);
      push_byte(1'b1, t[7:0]);
    end
    push_byte(1'b0, 8'hC0);
    for (int c = 0; c < 16; c++) begin
      t = s >> (120 - 8 * c);
      push_byte(1'b1, t[7:0]);
    end
    e = {1'b0, m_rs, m_d, 1'b0, 1'b1};
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Compare process: one model step per rising edge, sampled 1 time unit later.
  always @(posedge clk) begin
    exp_t ex, pu;
    #1;
    cyc++;
    if (rst) begin
      started = 1; rel = 0; armed = 1; prev_en = 1'b0; en_run = 0;
    end else begin
      rel++;
    end
    if (started) begin
      if (rst) begin
        q.delete();
        m_snap = '0; m_force = 0; m_rs = 1'b0; m_d = 8'h00;
        ex = {1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        pu = ex;
        for (int i = 0; i < PU - 1; i++) q.push_back(pu);
        push_byte(1'b0, 8'h38);
        push_byte(1'b0, 8'h0C);
        push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h01);
        m_force = 1;
      end else if (q.size() > 0) begin
        ex = q.pop_front();
      end else if (m_force || {top, bottom} != m_snap) begin
        m_force = 0;
        m_snap  = {top, bottom};
        build_frame(m_snap);
        ex = q.pop_front();
      end else begin
        ex = {1'b0, m_rs, m_d, 1'b0, 1'b0};
      end
      checks++;
      if ({lcd_en, lcd_rs, lcd_data, busy, frame_done, lcd_rw} !== {ex, 1'b0}) begin
        errors++;
        $display("FAIL bus cyc %0d: got en=%b rs=%b d=%02h busy=%b fd=%b rw=%b want en=%b rs=%b d=%02h busy=%b fd=%b rw=0",
                 cyc, lcd_en, lcd_rs, lcd_data, busy, frame_done, lcd_rw,
                 ex.en, ex.rs, ex.d, ex.busy, ex.fd);
      end
      if (!rst) begin
        if (lcd_en && !prev_en) begin
          slog.push_back(lcd_data);
          if (armed) begin
            armed = 0;
            checks++;
            if (rel != PU + 1 || lcd_data != 8'h38 || lcd_rs != 1'b0) begin
              errors++;
              $display("FAIL first_rise: got cycle %0d data %02h rs %b want cycle %0d data 38 rs 0",
                       rel, lcd_data, lcd_rs, PU + 1);
            end
          end
        end
        if (lcd_en) begin
          en_run++;
        end else if (prev_en) begin
          checks++;
          if (en_run != EN) begin
            errors++;
            $display("FAIL en_width: got %0d want %0d", en_run, EN);
          end
          en_run = 0;
        end
        if (frame_done) fd_n++;
        prev_en = lcd_en;
      end
    end
  end

  task automatic wait_strobes(input int n, input int budget, input string name);
    int k = 0;
    while (slog.size() < n && k < budget) begin @(negedge clk); k++; end
    checks++;
    if (slog.size() < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d strobes want %0d", name, slog.size(), n);
    end
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int k = 0;
    while (fd_n < n && k < budget) begin @(negedge clk); k++; end
    checks++;
    if (fd_n < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d frames want %0d", name, fd_n, n);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, en_hi, busy_hi, k, sel, pos;
    logic [127:0] v;
    logic [7:0]   b;
    rst    = 1'b1;
    top    = "   Win          ";
    bottom = "_ABCDEFGHIJKLMNO";
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Power-up, init burst and forced first frame.
    wait_frames(1, 2000, "first_frame");
    repeat (2) @(negedge clk);
    chk("strobes_first_frame", slog.size(), 38);
    chk("init0", slog[0], 8'h38);
    chk("init1", slog[1], 8'h0C);
    chk("init2", slog[2], 8'h06);
    chk("init3", slog[3], 8'h01);
    chk("row0_cmd", slog[4], 8'h80);
    chk("top_c0", slog[5], 8'h20);
    chk("top_c2", slog[7], 8'h20);
    chk("top_c3", slog[8], 8'h57);
    chk("top_c4", slog[9], 8'h69);
    chk("top_c5", slog[10], 8'h6E);
    chk("row1_cmd", slog[21], 8'hC0);
    chk("bot_c0", slog[22], 8'h5F);
    chk("frames_once", fd_n, 1);
    chk("busy_idle", busy, 0);

    // Steady inputs: no bus activity.
    en_hi = 0; busy_hi = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (lcd_en) en_hi++;
      if (busy) busy_hi++;
    end
    chk("idle_en_cycles", en_hi, 0);
    chk("idle_busy_cycles", busy_hi, 0);

    // Change during refresh: bottom column 0 changes at byte 10.
    base = slog.size();
    v = top; v[7:0] = 8'h58; top = v;
    wait_strobes(base + 11, 2000, "byte10");
    v = bottom; v[127:120] = 8'h41; bottom = v;
    wait_frames(3, 3000, "double_frame");
    repeat (2) @(negedge clk);
    chk("frame2_top_c15", slog[base + 16], 8'h58);
    chk("frame2_bot_c0", slog[base + 18], 8'h5F);
    chk("frame3_bot_c0", slog[base + 34 + 18], 8'h41);
    chk("frame3_strobes", slog.size(), base + 68);

    // Random text edits, some landing mid-refresh.
    for (int it = 0; it < 30; it++) begin
      k = $urandom_range(250, 0);
      repeat (k) @(negedge clk);
      sel = $urandom_range(2, 0);
      pos = $urandom_range(15, 0);
      b   = 8'($urandom_range(126, 32));
      if (sel == 0) begin v = top; v[8*pos +: 8] = b; top = v; end
      else if (sel == 1) begin v = bottom; v[8*pos +: 8] = b; bottom = v; end
    end
    k = 0;
    while (!(q.size() == 0 && !busy && {top, bottom} == m_snap) && k < 3000) begin
      @(negedge clk); k++;
    end
    chk("random_settle", (k < 3000) ? 1 : 0, 1);

    // Reset in the middle of a refresh, at byte 20.
    base = slog.size();
    v = top; v[127:120] = 8'h52; top = v;
    wait_strobes(base + 21, 2000, "byte20");
    k = fd_n;
    rst = 1'b1;
    @(posedge clk); #2;
    chk("rst_en", lcd_en, 0);
    chk("rst_busy", busy, 1);
    @(negedge clk);
    rst = 1'b0;
    wait_frames(k + 1, 3000, "restart_frame");
    chk("restart_init0", slog[base + 21], 8'h38);
    chk("restart_strobes", slog.size(), base + 21 + 38);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
